// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches sequential words from instruction
// memory into a small circular buffer, with branch redirect and flush.
module instr_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_adr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_done,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state;
   state_t        state_nx;
   logic [31:0]   fetch_pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;
   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];
   logic          push;
   logic          pop;

   // At most one request is outstanding, so in IDLE the issue rule
   // reduces to a free slot in the queue.
   always_comb begin
      state_nx = state;
      push     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!redirect && count < FULL)
               state_nx = WAIT;
         end
         WAIT: begin
            if (mem_done) begin
               state_nx = IDLE;
               push     = !redirect;
            end else if (redirect) begin
               state_nx = DROP;
            end
         end
         DROP: begin
            if (mem_done)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign pop       = out_valid && out_ready && !redirect;
   assign mem_req   = (state == WAIT);
   assign mem_adr   = fetch_pc;
   assign out_valid = (count != '0);
   assign out_pc    = q_pc[head];
   assign out_instr = q_instr[head];

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Fetch address: redirect wins, otherwise advance on each accepted word
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_pc <= RESET_PC;
      else if (redirect)
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (push)
         fetch_pc <= fetch_pc + 32'd4;
   end

   // Queue pointers and occupancy; redirect flushes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)
            tail <= tail + AW'(1);
         if (pop)
            head <= head + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage written at the tail; head is read straight from here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (push) begin
         q_pc[tail]    <= fetch_pc;
         q_instr[tail] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: directed scenarios push expected
// {pc, instr} pairs; a monitor compares each accepted head entry.
module tb_instr_prefetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_adr;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int          checks = 0;
   int          errors = 0;
   int          reqs   = 0;
   logic        req_prev = 1'b0;
   logic [63:0] exp_q [$];

   bit          mem_auto = 1'b1;
   int          lat      = 1;
   bit          busy     = 1'b0;
   int          wcnt     = 0;
   logic [31:0] radr     = '0;

   instr_prefetch dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_adr     (mem_adr),
      .mem_rdata   (mem_rdata),
      .mem_done    (mem_done),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] img(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back({pc, img(pc)});
   endtask

   // Memory model: answers the request after lat cycles, even if dropped
   always @(negedge clk) begin
      if (mem_auto) begin
         if (rst) begin
            busy     = 1'b0;
            mem_done = 1'b0;
         end else if (mem_done) begin
            mem_done = 1'b0;
         end else begin
            if (!busy && mem_req) begin
               busy = 1'b1;
               wcnt = 0;
               radr = mem_adr;
            end
            if (busy) begin
               wcnt++;
               if (wcnt >= lat) begin
                  mem_done  = 1'b1;
                  mem_rdata = img(radr);
                  busy      = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: compares every accepted head entry against the scoreboard
   always @(negedge clk) begin
      logic [63:0] e;
      #1;
      if (rst) begin
         req_prev = 1'b0;
      end else begin
         if (mem_req && !req_prev)
            reqs++;
         req_prev = mem_req;
         if (out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h, expected none",
                        out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("pop_pc", out_pc, e[63:32]);
               chk("pop_instr", out_instr, e[31:0]);
            end
         end
      end
   end

   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(nm, exp_q.size(), 0);
      out_ready = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      while (!mem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(nm, {31'b0, mem_req}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b0;
      redirect  = 1'b0;
      mem_done  = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      reqs = 0;
   endtask

   initial begin
      rst         = 1'b1;
      out_ready   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_done    = 1'b0;
      mem_rdata   = '0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_adr", mem_adr, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);

      // Sequential stream, 1-cycle memory, consumer always ready
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("first_req", {31'b0, mem_req}, 32'd1);
      chk("first_adr", mem_adr, 32'h0);
      for (int i = 0; i < 8; i++)
         push_exp(32'(i * 4));
      out_ready = 1'b1;
      drain("seq_drain");

      // Back-pressure: queue fills and issue stops
      do_reset();
      repeat (20) @(negedge clk);
      chk("full_reqs", reqs, 32'd4);
      chk("full_valid", {31'b0, out_valid}, 32'd1);
      chk("full_pc", out_pc, 32'h0);
      chk("full_instr", out_instr, img(32'h0));
      chk("full_mem_req", {31'b0, mem_req}, 32'd0);
      for (int i = 0; i < 4; i++)
         push_exp(32'(i * 4));
      out_ready = 1'b1;
      drain("full_drain");

      // Redirect while a slow request is pending
      do_reset();
      lat = 5;
      wait_req("slow_req");
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect = 1'b0;
      chk("drop_mem_req", {31'b0, mem_req}, 32'd0);
      chk("drop_valid", {31'b0, out_valid}, 32'd0);
      push_exp(32'h100);
      push_exp(32'h104);
      wait_req("drop_newreq");
      chk("drop_new_adr", mem_adr, 32'h100);
      out_ready = 1'b1;
      drain("drop_drain");
      lat = 1;

      // Redirect coincident with mem_done and pop; unaligned target
      mem_auto = 1'b0;
      do_reset();
      wait_req("co_req0");
      chk("co_adr0", mem_adr, 32'h0);
      mem_done  = 1'b1;
      mem_rdata = img(32'h0);
      @(negedge clk);
      mem_done = 1'b0;
      wait_req("co_req1");
      chk("co_adr1", mem_adr, 32'h4);
      chk("co_valid_pre", {31'b0, out_valid}, 32'd1);
      mem_done    = 1'b1;
      mem_rdata   = img(32'h4);
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      out_ready   = 1'b1;
      @(negedge clk);
      mem_done  = 1'b0;
      redirect  = 1'b0;
      out_ready = 1'b0;
      chk("co_valid_post", {31'b0, out_valid}, 32'd0);
      chk("co_adr", mem_adr, 32'h200);
      chk("co_mem_req", {31'b0, mem_req}, 32'd0);
      push_exp(32'h200);
      push_exp(32'h204);
      push_exp(32'h208);
      mem_auto  = 1'b1;
      out_ready = 1'b1;
      drain("co_drain");

      // Redirect in IDLE to the last word, then wrap to zero
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      chk("wrap_suppress", {31'b0, mem_req}, 32'd0);
      chk("wrap_adr", mem_adr, 32'hFFFF_FFFC);
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0);
      push_exp(32'h4);
      out_ready = 1'b1;
      drain("wrap_drain");

      // Reset during WAIT, stale done during and after reset
      mem_auto = 1'b0;
      do_reset();
      wait_req("rw_req");
      chk("rw_adr", mem_adr, 32'h0);
      rst       = 1'b1;
      mem_done  = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      #1;
      chk("rw_req_drop", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      reqs = 0;
      @(negedge clk);
      mem_done = 1'b0;
      chk("rw_req_again", {31'b0, mem_req}, 32'd1);
      chk("rw_adr_again", mem_adr, 32'h0);
      chk("rw_valid", {31'b0, out_valid}, 32'd0);
      push_exp(32'h0);
      push_exp(32'h4);
      mem_auto  = 1'b1;
      out_ready = 1'b1;
      drain("rw_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  read request to instruction memory.
REQ-006 SHALL have port mem_adr  output  32  read address, word aligned.
REQ-007 SHALL have port mem_rdata  input  32  read data, valid when mem_done=1.
REQ-008 SHALL have port mem_done  input  1  one-cycle completion pulse for the outstanding request.
REQ-009 SHALL have port out_valid  output  1  head entry available to the fetch stage.
REQ-010 SHALL have port out_instr  output  32  head instruction.
REQ-011 SHALL have port out_pc  output  32  address of head instruction.
REQ-012 SHALL have port out_ready  input  1  fetch stage accepts head; pop when out_valid and out_ready.
REQ-013 SHALL have port redirect  input  1  taken branch/jump; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.

Function
REQ-015 SHALL keep a circular queue of DEPTH {pc, instr} entries; head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-016 SHALL implement FSM states IDLE, WAIT, DROP.
REQ-017 IDLE: when count < DEPTH and redirect=0, SHALL assert mem_req with mem_adr=fetch_pc and move to WAIT the next cycle.
REQ-018 WAIT: SHALL hold mem_req=1 and mem_adr stable until mem_done=1; at most one request SHALL be outstanding.
REQ-019 WAIT with mem_done=1 and redirect=0: SHALL push {fetch_pc, mem_rdata} at tail, set fetch_pc=fetch_pc+4 (mod 2^32), return to IDLE.
REQ-020 Issue rule: a request SHALL be issued only if count plus outstanding requests is less than DEPTH, so a push never meets a full queue.
REQ-021 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL come from head registers, no combinational path from mem_rdata.
REQ-022 Push and pop in the same cycle SHALL both take effect; count is unchanged.
REQ-023 Latency: mem_done in cycle N with empty queue SHALL give out_valid=1 in cycle N+1.
REQ-024 redirect=1 SHALL, next cycle: empty the queue (count=0, out_valid=0), set fetch_pc={redirect_pc[31:2],2'b00}; redirect overrides a same-cycle pop or push.
REQ-025 redirect in WAIT without mem_done SHALL move to DROP; mem_req SHALL deassert; the next mem_done SHALL be discarded, then IDLE.
REQ-026 redirect in WAIT with mem_done in the same cycle SHALL discard that data and go to IDLE.
REQ-027 redirect in DROP SHALL update fetch_pc again and stay in DROP.
REQ-028 redirect in IDLE SHALL suppress issue that cycle; issue from the new pc SHALL start the following cycle.
REQ-029 mem_done outside WAIT/DROP SHALL be ignored.
REQ-030 Behaviour with out_ready=1 while out_valid=0 SHALL be a no-op.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, count 0, pointers 0, fetch_pc=RESET_PC, mem_req=0, mem_adr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
REQ-032 rst asserted mid-WAIT SHALL abandon the request; mem_done arriving during or after reset SHALL be discarded.
REQ-033 First mem_req SHALL assert in the first clock edge after rst deasserts.

Verification
REQ-034 Reset, memory with 1-cycle done, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, instr matches memory image, no gaps after warm-up.
REQ-035 out_ready=0 for 20 cycles -> exactly 4 requests issued, out_valid=1, out_pc=0x0 held, mem_req=0 once full; releasing out_ready drains 0x0..0xC in order.
REQ-036 Memory latency 5 cycles, redirect to 0x100 two cycles after mem_req -> stale response dropped, next mem_adr=0x100, first out_pc=0x100.
REQ-037 redirect_pc=0x203 coincident with mem_done and pop -> queue empty next cycle, mem_adr=0x200, no entry from old stream appears.
REQ-038 fetch_pc=0xFFFFFFFC, sequential fetch -> next out_pc=0x0 (wrap).
REQ-039 rst pulsed while in WAIT, mem_done arriving one cycle after release -> that data discarded, first out_pc=RESET_PC.
